// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline stall/flush/halt controller.
// The step state is only reachable when PIPE_CTRL_SINGLE_STEP_EN is defined.
package pipe_ctrl_pkg;

  localparam int unsigned CNT_W_DEFAULT = 32;
  localparam logic [4:0]  REG_ZERO      = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALTED,
    ST_RELEASE,
    ST_STEP
  } state_t;

  typedef struct packed {
    logic pc_stop;
    logic ifid_stop;
    logic ifid_nop;
    logic idex_stop;
    logic idex_nop;
    logic exmem_stop;
    logic memwb_stop;
  } ctrl_t;

  // Whole-pipe hold: every stage register keeps its contents, no bubbles.
  function automatic ctrl_t ctrl_freeze();
    ctrl_t c;
    c            = '0;
    c.pc_stop    = 1'b1;
    c.ifid_stop  = 1'b1;
    c.idex_stop  = 1'b1;
    c.exmem_stop = 1'b1;
    c.memwb_stop = 1'b1;
    return c;
  endfunction

  // Taken branch: squash the two wrong-path instructions behind EX.
  function automatic ctrl_t ctrl_flush();
    ctrl_t c;
    c          = '0;
    c.ifid_nop = 1'b1;
    c.idex_nop = 1'b1;
    return c;
  endfunction

  // Load-use: hold PC and IF/ID, bubble into EX, let the load move on.
  function automatic ctrl_t ctrl_load_use();
    ctrl_t c;
    c           = '0;
    c.pc_stop   = 1'b1;
    c.ifid_stop = 1'b1;
    c.idex_nop  = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard compare between the ID operands and the EX load.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_use_rs1,
  input  logic       i_id_use_rs2,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rd,
  output logic       o_load_use_hazard
);

  logic w_rs1_match;
  logic w_rs2_match;
  logic w_rd_live;

  assign w_rd_live   = i_ex_mem_read & (i_ex_rd != REG_ZERO);
  assign w_rs1_match = i_id_use_rs1 & (i_id_rs1 == i_ex_rd);
  assign w_rs2_match = i_id_use_rs2 & (i_id_rs2 == i_ex_rd);

  assign o_load_use_hazard = w_rd_live & (w_rs1_match | w_rs2_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/halt scheduler for the 5-stage RV32I pipeline, plus debug counters.
// Optional single-step from halt: define PIPE_CTRL_SINGLE_STEP_EN.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  input  logic             wb_ebreak,
  input  logic             wb_nop,
  input  logic             resume,
  input  logic             step,
  output logic             pc_stop,
  output logic             ifid_stop,
  output logic             ifid_nop,
  output logic             idex_stop,
  output logic             idex_nop,
  output logic             exmem_stop,
  output logic             memwb_stop,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  state_t           r_state;
  state_t           w_next_state;
  ctrl_t            w_ctrl;
  logic             w_load_use;
  logic             w_halt_entry;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instret_cnt;

`ifndef PIPE_CTRL_SINGLE_STEP_EN
  logic w_step_unused;
  assign w_step_unused = step;
`endif

  hazard_detect u_hazard_detect (
    .i_id_rs1          (id_rs1),
    .i_id_rs2          (id_rs2),
    .i_id_use_rs1      (id_use_rs1),
    .i_id_use_rs2      (id_use_rs2),
    .i_ex_mem_read     (ex_mem_read),
    .i_ex_rd           (ex_rd),
    .o_load_use_hazard (w_load_use)
  );

  // Only RUN honours ebreak; RELEASE/STEP must let the resident ebreak retire.
  assign w_halt_entry = (r_state == ST_RUN) & wb_ebreak & ~wb_nop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_ctrl       = '0;

    case (r_state)
      ST_RUN: begin
        if (w_halt_entry) begin
          w_next_state = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (resume) begin
          w_next_state = ST_RELEASE;
        end
`ifdef PIPE_CTRL_SINGLE_STEP_EN
        else if (step) begin
          w_next_state = ST_STEP;
        end
`endif
      end
      ST_RELEASE: begin
        w_next_state = ST_RUN;
      end
`ifdef PIPE_CTRL_SINGLE_STEP_EN
      ST_STEP: begin
        w_next_state = ST_HALTED;
      end
`endif
      default: begin
        w_next_state = ST_RUN;
      end
    endcase

    if ((r_state == ST_HALTED) || w_halt_entry || mem_busy) begin
      w_ctrl = ctrl_freeze();
    end else if (ex_branch_taken) begin
      w_ctrl = ctrl_flush();
    end else if (w_load_use) begin
      w_ctrl = ctrl_load_use();
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      if (r_state != ST_HALTED) begin
        r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      end
      if (!wb_nop && !w_ctrl.memwb_stop) begin
        r_instret_cnt <= r_instret_cnt + CNT_W'(1);
      end
    end
  end

  assign pc_stop     = w_ctrl.pc_stop;
  assign ifid_stop   = w_ctrl.ifid_stop;
  assign ifid_nop    = w_ctrl.ifid_nop;
  assign idex_stop   = w_ctrl.idex_stop;
  assign idex_nop    = w_ctrl.idex_nop;
  assign exmem_stop  = w_ctrl.exmem_stop;
  assign memwb_stop  = w_ctrl.memwb_stop;
  assign halted      = (r_state == ST_HALTED);
  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table, directed corner sequences, random vs model.
module tb_pipeline_ctrl;

  localparam int unsigned TB_CNT_W = 4;
  localparam int unsigned CMASK    = (1 << TB_CNT_W) - 1;
`ifdef PIPE_CTRL_SINGLE_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, mem_busy;
  logic wb_ebreak, wb_nop, resume, step;
  logic pc_stop, ifid_stop, ifid_nop, idex_stop, idex_nop, exmem_stop, memwb_stop, halted;
  logic [TB_CNT_W-1:0] cycle_cnt, instret_cnt;

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy), .wb_ebreak(wb_ebreak), .wb_nop(wb_nop), .resume(resume), .step(step),
    .pc_stop(pc_stop), .ifid_stop(ifid_stop), .ifid_nop(ifid_nop), .idex_stop(idex_stop),
    .idex_nop(idex_nop), .exmem_stop(exmem_stop), .memwb_stop(memwb_stop), .halted(halted),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic use1, use2, mread, br, busy, ebrk, wbnop, res, stp;
  } in_t;

  typedef struct {
    string      name;
    in_t        v;
    logic [6:0] exp;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Model: halted mode plus a pending one-cycle window that either ends in RUN or back in halt.
  bit m_halted, m_window, m_window_rehalt;
  int unsigned m_cycle, m_instret;

  in_t IDLE;

  // Output vector order: {pc_stop, ifid_stop, ifid_nop, idex_stop, idex_nop, exmem_stop, memwb_stop}
  function automatic logic [6:0] actual_ctrl();
    return {pc_stop, ifid_stop, ifid_nop, idex_stop, idex_nop, exmem_stop, memwb_stop};
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic bit model_ebreak(in_t v);
    return v.ebrk && !v.wbnop && !m_halted && !m_window;
  endfunction

  function automatic logic [6:0] model_ctrl(in_t v);
    bit hz;
    hz = v.mread && (v.rd != 0) &&
         ((v.use1 && v.rs1 == v.rd) || (v.use2 && v.rs2 == v.rd));
    if (m_halted || model_ebreak(v) || v.busy) return 7'b1101011;
    if (v.br)                                  return 7'b0010100;
    if (hz)                                    return 7'b1100100;
    return 7'b0000000;
  endfunction

  function automatic void model_reset();
    m_halted = 0; m_window = 0; m_window_rehalt = 0; m_cycle = 0; m_instret = 0;
  endfunction

  function automatic void model_step(in_t v, logic [6:0] ctl);
    bit eb;
    eb = model_ebreak(v);
    if (!m_halted) m_cycle = (m_cycle + 1) & CMASK;
    if (!v.wbnop && !ctl[0]) m_instret = (m_instret + 1) & CMASK;
    if (m_halted) begin
      if (v.res) begin
        m_halted = 0; m_window = 1; m_window_rehalt = 0;
      end else if (STEP_EN && v.stp) begin
        m_halted = 0; m_window = 1; m_window_rehalt = 1;
      end
    end else if (m_window) begin
      m_halted = m_window_rehalt; m_window = 0;
    end else if (eb) begin
      m_halted = 1;
    end
  endfunction

  task automatic apply_inputs(in_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.use1; id_use_rs2 = v.use2;
    ex_mem_read = v.mread; ex_rd = v.rd; ex_branch_taken = v.br; mem_busy = v.busy;
    wb_ebreak = v.ebrk; wb_nop = v.wbnop; resume = v.res; step = v.stp;
  endtask

  // Called at posedge+1; checks mid-cycle, then advances the model across one edge.
  task automatic drive(in_t v, output logic [6:0] act);
    logic [6:0] exp;
    apply_inputs(v);
    #2;
    exp = model_ctrl(v);
    act = actual_ctrl();
    chk("ctrl", 32'(act), 32'(exp));
    chk("halted", 32'(halted), 32'(m_halted));
    chk("cycle_cnt", 32'(cycle_cnt), m_cycle);
    chk("instret_cnt", 32'(instret_cnt), m_instret);
    @(posedge clk);
    model_step(v, exp);
    #1;
  endtask

  task automatic do_reset();
    apply_inputs(IDLE);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  vec_t        tbl[$];
  vec_t        t;
  in_t         v;
  logic [6:0]  act;
  int unsigned c0, i0;

  initial begin
    IDLE = '{rs1:0, rs2:0, rd:0, use1:0, use2:0, mread:0, br:0, busy:0,
             ebrk:0, wbnop:1, res:0, stp:0};
    apply_inputs(IDLE);
    rst = 1'b1;
    model_reset();
    #3;
    chk("reset_ctrl", 32'(actual_ctrl()), 32'h0);
    chk("reset_halted", 32'(halted), 32'h0);
    chk("reset_cycle", 32'(cycle_cnt), 32'h0);
    chk("reset_instret", 32'(instret_cnt), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ---- vector table, single cycles in RUN ----
    t.v = IDLE; t.v.mread = 1; t.v.rd = 5; t.v.rs1 = 5; t.v.use1 = 1;
    t.name = "lu_rs1";        t.exp = 7'b1100100; tbl.push_back(t);
    t.v = IDLE; t.v.mread = 1; t.v.rd = 0; t.v.rs1 = 0; t.v.use1 = 1;
    t.name = "lu_x0";         t.exp = 7'b0000000; tbl.push_back(t);
    t.v = IDLE; t.v.mread = 1; t.v.rd = 7; t.v.rs2 = 7; t.v.use2 = 1; t.v.rs1 = 3; t.v.use1 = 1;
    t.name = "lu_rs2";        t.exp = 7'b1100100; tbl.push_back(t);
    t.v = IDLE; t.v.mread = 1; t.v.rd = 5; t.v.rs1 = 5; t.v.use1 = 0;
    t.name = "lu_unused_rs";  t.exp = 7'b0000000; tbl.push_back(t);
    t.v = IDLE; t.v.mread = 0; t.v.rd = 5; t.v.rs1 = 5; t.v.use1 = 1;
    t.name = "no_load";       t.exp = 7'b0000000; tbl.push_back(t);
    t.v = IDLE; t.v.mread = 1; t.v.rd = 5; t.v.rs1 = 5; t.v.use1 = 1; t.v.br = 1;
    t.name = "br_over_lu";    t.exp = 7'b0010100; tbl.push_back(t);
    t.v = IDLE; t.v.br = 1;
    t.name = "br_only";       t.exp = 7'b0010100; tbl.push_back(t);
    t.v = IDLE; t.v.br = 1; t.v.busy = 1; t.v.mread = 1; t.v.rd = 9; t.v.rs1 = 9; t.v.use1 = 1;
    t.name = "busy_over_all"; t.exp = 7'b1101011; tbl.push_back(t);
    t.v = IDLE; t.v.ebrk = 1; t.v.wbnop = 1;
    t.name = "ebreak_nop";    t.exp = 7'b0000000; tbl.push_back(t);
    t.v = IDLE; t.v.wbnop = 0;
    t.name = "idle_retire";   t.exp = 7'b0000000; tbl.push_back(t);
    foreach (tbl[k]) begin
      drive(tbl[k].v, act);
      chk(tbl[k].name, 32'(act), 32'(tbl[k].exp));
    end

    // ---- mem_busy for 3 cycles with a branch pending ----
    do_reset();
    c0 = m_cycle; i0 = m_instret;
    v = IDLE; v.busy = 1; v.br = 1; v.wbnop = 0;
    for (int k = 0; k < 3; k++) begin
      drive(v, act);
      chk("busy_freeze", 32'(act), 32'h6B);
    end
    chk("busy_cycle+3", 32'(cycle_cnt), (c0 + 3) & CMASK);
    chk("busy_instret_held", 32'(instret_cnt), i0);

    // ---- ebreak halt, frozen cycle count, resume ----
    v = IDLE; v.ebrk = 1; v.wbnop = 0;
    drive(v, act);
    chk("halt_entry_freeze", 32'(act), 32'h6B);
    chk("halted_next", 32'(halted), 32'h1);
    c0 = m_cycle; i0 = m_instret;
    for (int k = 0; k < 10; k++) drive(v, act);
    chk("halt_cycle_frozen", 32'(cycle_cnt), c0);
    chk("halt_instret_frozen", 32'(instret_cnt), i0);
    v.res = 1; drive(v, act);
    v.res = 0; drive(v, act);
    chk("release_open", 32'(act), 32'h0);
    chk("release_instret+1", 32'(instret_cnt), (i0 + 1) & CMASK);
    v = IDLE; v.wbnop = 0; v.res = 1;
    drive(v, act);
    chk("run_no_rehalt", 32'(halted), 32'h0);

    // ---- instret wrap at CNT_W=4 ----
    do_reset();
    v = IDLE; v.wbnop = 0;
    for (int k = 0; k < 15; k++) drive(v, act);
    chk("instret_15", 32'(instret_cnt), 32'd15);
    drive(v, act);
    chk("instret_wrap", 32'(instret_cnt), 32'd0);

    // ---- async reset in the middle of HALTED ----
    v = IDLE; v.ebrk = 1; v.wbnop = 0;
    drive(v, act);
    drive(v, act);
    apply_inputs(IDLE);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_halted", 32'(halted), 32'h0);
    chk("arst_cycle", 32'(cycle_cnt), 32'h0);
    chk("arst_instret", 32'(instret_cnt), 32'h0);
    chk("arst_ctrl", 32'(actual_ctrl()), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // ---- single step ----
    v = IDLE; v.ebrk = 1; v.wbnop = 0;
    drive(v, act);
    v.stp = 1; drive(v, act);
`ifdef PIPE_CTRL_SINGLE_STEP_EN
    v.stp = 0; drive(v, act);
    chk("step_open", 32'(act), 32'h0);
    chk("step_rehalt", 32'(halted), 32'h1);
    v.stp = 1; v.res = 1; drive(v, act);
    v.stp = 0; v.res = 0; drive(v, act);
    chk("step_res_release", 32'(act), 32'h0);
    v = IDLE; drive(v, act);
    chk("step_res_run", 32'(halted), 32'h0);
`else
    v.stp = 0; drive(v, act);
    chk("step_ignored_ctrl", 32'(act), 32'h6B);
    chk("step_ignored_halt", 32'(halted), 32'h1);
    v.res = 1; drive(v, act);
    v = IDLE; drive(v, act);
    drive(v, act);
    chk("resume_exit", 32'(halted), 32'h0);
`endif

    // ---- randomized traffic against the model ----
    do_reset();
    for (int k = 0; k < 600; k++) begin
      v.rs1   = 5'($urandom_range(0, 7));
      v.rs2   = 5'($urandom_range(0, 7));
      v.rd    = 5'($urandom_range(0, 7));
      v.use1  = 1'($urandom_range(0, 1));
      v.use2  = 1'($urandom_range(0, 1));
      v.mread = 1'($urandom_range(0, 1));
      v.br    = ($urandom_range(0, 4) == 0);
      v.busy  = ($urandom_range(0, 5) == 0);
      v.ebrk  = ($urandom_range(0, 11) == 0);
      v.wbnop = ($urandom_range(0, 3) == 0);
      v.res   = ($urandom_range(0, 5) == 0);
      v.stp   = ($urandom_range(0, 4) == 0);
      drive(v, act);
      if (k == 300) begin
        apply_inputs(IDLE);
        rst = 1'b1; #1;
        chk("rand_arst_halted", 32'(halted), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
